// File: rtl/map_tile_fetcher_pkg.sv
// ============================================================================
// map_tile_fetcher_pkg : tile-map geometry shared by ROM, fetcher and renderer
// Revision: 1.0
// ============================================================================
`default_nettype none

package map_tile_fetcher_pkg;
    localparam int RAM_WIDTH     = 5;
    localparam int RAM_ADDR_BITS = 11;
    localparam int MAP_COLS      = 100;
    localparam int MAP_ROWS      = 15;
    localparam int TILE_BITS     = 5;
    localparam int VIS_TILES     = 21;
    localparam int H_VISIBLE     = 640;
    localparam int COL_BITS      = 7;
    localparam int ROW_BITS      = 4;
    localparam int IDX_BITS      = 5;

    typedef logic [RAM_WIDTH-1:0] tile_id_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic [RAM_ADDR_BITS-1:0] row_base(input logic [ROW_BITS-1:0] row);
        return RAM_ADDR_BITS'(row) * RAM_ADDR_BITS'(MAP_COLS);
    endfunction
endpackage

`default_nettype wire

// File: rtl/map_tile_fetcher_line_buffer.sv
// ============================================================================
// tile_line_buffer : two-bank tile row cache, write to back, registered read of front
// Revision: 1.0
// ============================================================================
`default_nettype none

module tile_line_buffer
    import map_tile_fetcher_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 swap,
    input  logic                 wr_en,
    input  logic [IDX_BITS-1:0]  wr_idx,
    input  logic [RAM_WIDTH-1:0] wr_data,
    input  logic                 rd_valid,
    input  logic [IDX_BITS-1:0]  rd_idx,
    input  logic [TILE_BITS-1:0] rd_px,
    output logic [RAM_WIDTH-1:0] tile_id,
    output logic [TILE_BITS-1:0] tile_px
);
    tile_id_t             bank_q [2][VIS_TILES];
    tile_id_t             bank_d [2][VIS_TILES];
    logic                 bank_sel_q, bank_sel_d;
    tile_id_t             tile_id_q, tile_id_d;
    logic [TILE_BITS-1:0] tile_px_q, tile_px_d;

    always_comb begin
        bank_d     = bank_q;
        bank_sel_d = bank_sel_q ^ swap;
        if (wr_en) begin
            bank_d[~bank_sel_q][wr_idx] = wr_data;
        end
        tile_id_d = '0;
        tile_px_d = '0;
        if (rd_valid) begin
            tile_id_d = bank_q[bank_sel_q][rd_idx];
            tile_px_d = rd_px;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q     <= '{default: '0};
            bank_sel_q <= 1'b0;
            tile_id_q  <= '0;
            tile_px_q  <= '0;
        end else begin
            bank_q     <= bank_d;
            bank_sel_q <= bank_sel_d;
            tile_id_q  <= tile_id_d;
            tile_px_q  <= tile_px_d;
        end
    end

    assign tile_id = tile_id_q;
    assign tile_px = tile_px_q;
endmodule

`default_nettype wire

// File: rtl/map_tile_fetcher.sv
// ============================================================================
// map_tile_fetcher : map ROM row prefetch with horizontal scroll and column wrap
// Revision: 1.0
// ============================================================================
`default_nettype none

module map_tile_fetcher
    import map_tile_fetcher_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic [9:0]  line_y,
    input  logic [11:0] scroll_x,
    input  logic [9:0]  px_x,
    output logic        map_en,
    output logic [10:0] map_addr,
    input  logic [4:0]  map_data,
    output logic [4:0]  tile_id,
    output logic [4:0]  tile_px,
    output logic        busy,
    output logic        overrun
);
    fetch_state_e             state_q, state_d;
    logic [IDX_BITS-1:0]      idx_q, idx_d;
    logic [COL_BITS-1:0]      col_q, col_d;
    logic [RAM_ADDR_BITS-1:0] row_base_q, row_base_d;
    logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
    logic                     fetch_done_q, fetch_done_d;
    logic                     overrun_q, overrun_d;
    logic [11:0]              scroll_q, scroll_d;
    logic                     wr_en_q, wr_en_d;
    logic [IDX_BITS-1:0]      wr_idx_q, wr_idx_d;

    logic                     busy_w, swap_w, start_w;
    logic [ROW_BITS-1:0]      start_row_w;
    logic [COL_BITS-1:0]      start_col_w, col_next_w;
    logic [4:0]               line_row_w;
    logic [10:0]              s_w;

    assign busy_w     = (state_q != ST_IDLE);
    assign line_row_w = line_y[9:5];
    assign col_next_w = (col_q == COL_BITS'(MAP_COLS - 1)) ? '0 : col_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        col_d        = col_q;
        row_base_d   = row_base_q;
        addr_d       = addr_q;
        fetch_done_d = fetch_done_q;
        overrun_d    = overrun_q;
        scroll_d     = scroll_q;
        wr_en_d      = (state_q == ST_ISSUE);
        wr_idx_d     = idx_q;
        swap_w       = 1'b0;
        start_w      = 1'b0;
        start_row_w  = '0;
        start_col_w  = scroll_q[11:5];

        // frame_start outranks everything: it clears overrun and aborts any fetch
        if (frame_start) begin
            overrun_d   = 1'b0;
            scroll_d    = scroll_x;
            start_w     = 1'b1;
            start_col_w = scroll_x[11:5];
        end else if (line_start) begin
            if (line_y[4:0] == 5'd31 && line_row_w < 5'(MAP_ROWS - 1)) begin
                if (busy_w) begin
                    overrun_d = 1'b1;
                end else begin
                    start_w     = 1'b1;
                    start_row_w = ROW_BITS'(line_row_w + 5'd1);
                end
            end
            if (line_y[4:0] == 5'd0) begin
                if (fetch_done_q && !busy_w) begin
                    swap_w       = 1'b1;
                    fetch_done_d = 1'b0;
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end

        case (state_q)
            ST_IDLE: ;
            ST_ISSUE: begin
                if (idx_q == IDX_BITS'(VIS_TILES - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    idx_d  = idx_q + 1'b1;
                    col_d  = col_next_w;
                    addr_d = row_base_q + RAM_ADDR_BITS'(col_next_w);
                end
            end
            ST_DRAIN: begin
                state_d      = ST_IDLE;
                fetch_done_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_w) begin
            state_d      = ST_ISSUE;
            idx_d        = '0;
            col_d        = start_col_w;
            row_base_d   = row_base(start_row_w);
            addr_d       = row_base(start_row_w) + RAM_ADDR_BITS'(start_col_w);
            fetch_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            col_q        <= '0;
            row_base_q   <= '0;
            addr_q       <= '0;
            fetch_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            scroll_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_idx_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            col_q        <= col_d;
            row_base_q   <= row_base_d;
            addr_q       <= addr_d;
            fetch_done_q <= fetch_done_d;
            overrun_q    <= overrun_d;
            scroll_q     <= scroll_d;
            wr_en_q      <= wr_en_d;
            wr_idx_q     <= wr_idx_d;
        end
    end

    assign s_w = {1'b0, px_x} + {6'b0, scroll_q[4:0]};

    tile_line_buffer u_line_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .swap     (swap_w),
        .wr_en    (wr_en_q),
        .wr_idx   (wr_idx_q),
        .wr_data  (map_data),
        .rd_valid (px_x < 10'(H_VISIBLE)),
        .rd_idx   (IDX_BITS'(s_w >> TILE_BITS)),
        .rd_px    (s_w[4:0]),
        .tile_id  (tile_id),
        .tile_px  (tile_px)
    );

    assign map_en   = (state_q == ST_ISSUE);
    assign map_addr = addr_q;
    assign busy     = busy_w;
    assign overrun  = overrun_q;
endmodule

`default_nettype wire

// File: tb/tb_map_tile_fetcher.sv
// ============================================================================
// tb_map_tile_fetcher : directed bench with ROM model and behavioural reference
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_map_tile_fetcher;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start, line_start;
    logic [9:0]  line_y;
    logic [11:0] scroll_x;
    logic [9:0]  px_x;
    logic        map_en;
    logic [10:0] map_addr;
    logic [4:0]  map_data = '0;
    logic [4:0]  tile_id, tile_px;
    logic        busy, overrun;

    int vectors = 0;
    int miscompares = 0;
    int addr_log[$];

    map_tile_fetcher dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .line_start(line_start),
        .line_y(line_y), .scroll_x(scroll_x), .px_x(px_x), .map_en(map_en),
        .map_addr(map_addr), .map_data(map_data), .tile_id(tile_id), .tile_px(tile_px),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // ROM contents: map[a] = a mod 32, one cycle of read latency
    always @(posedge clk) if (map_en) map_data <= 5'(map_addr % 11'd32);

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: fetch progress counted as busy cycles 1..22, row content from arithmetic
    int m_fcyc, m_row, m_cb, m_sel, m_latch;
    bit m_done, m_ovr;
    int m_bank[2][21];
    bit e_en, e_busy;
    int e_addr, e_tid, e_tpx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fcyc = 0; m_row = 0; m_cb = 0; m_sel = 0; m_latch = 0;
            m_done = 0; m_ovr = 0;
            for (int b = 0; b < 2; b++) for (int i = 0; i < 21; i++) m_bank[b][i] = 0;
            e_en = 0; e_busy = 0; e_addr = 0; e_tid = 0; e_tpx = 0;
        end else begin
            int s, nrow, ncb;
            bit busy0, done0, start;
            s = int'(px_x) + (m_latch % 32);
            if (px_x >= 640) begin
                e_tid = 0; e_tpx = 0;
            end else begin
                e_tid = m_bank[m_sel][s / 32]; e_tpx = s % 32;
            end
            busy0 = (m_fcyc > 0); done0 = m_done; start = 0; nrow = 0; ncb = 0;
            if (frame_start) begin
                m_ovr = 0; m_latch = int'(scroll_x); start = 1; nrow = 0; ncb = m_latch / 32;
            end else if (line_start) begin
                if (line_y % 32 == 31 && line_y / 32 < 14) begin
                    if (busy0) m_ovr = 1;
                    else begin start = 1; nrow = int'(line_y) / 32 + 1; ncb = m_latch / 32; end
                end
                if (line_y % 32 == 0) begin
                    if (done0 && !busy0) begin m_sel = 1 - m_sel; m_done = 0; end
                    else m_ovr = 1;
                end
            end
            if (start) begin
                m_fcyc = 1; m_row = nrow; m_cb = ncb; m_done = 0;
            end else if (m_fcyc == 22) begin
                m_fcyc = 0; m_done = 1;
                for (int i = 0; i < 21; i++)
                    m_bank[1 - m_sel][i] = (m_row * 100 + (m_cb + i) % 100) % 32;
            end else if (m_fcyc > 0) begin
                m_fcyc++;
            end
            e_busy = (m_fcyc > 0);
            e_en   = (m_fcyc >= 1 && m_fcyc <= 21);
            if (e_en) e_addr = m_row * 100 + (m_cb + m_fcyc - 1) % 100;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("map_en", map_en, e_en);
            check("map_addr", map_addr, e_addr);
            check("busy", busy, e_busy);
            check("overrun", overrun, m_ovr);
            check("tile_id", tile_id, e_tid);
            check("tile_px", tile_px, e_tpx);
            if (map_en) begin
                check("rom_range", map_addr <= 11'd1499, 1);
                addr_log.push_back(int'(map_addr));
            end
        end
    end

    function automatic int log_at(input int i);
        return (i < addr_log.size()) ? addr_log[i] : -1;
    endfunction

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic pulse_frame(input int sx);
        scroll_x = 12'(sx); frame_start = 1'b1; tick(); frame_start = 1'b0;
    endtask

    task automatic pulse_line(input int y);
        line_y = 10'(y); line_start = 1'b1; tick(); line_start = 1'b0;
    endtask

    task automatic read_px(input int x, input int tid, input int tpx, input string name);
        px_x = 10'(x); tick();
        check({name, "_tid"}, tile_id, tid);
        check({name, "_tpx"}, tile_px, tpx);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin tick(); n++; end
        check("wait_idle", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_start = 0; line_start = 0; line_y = 0; scroll_x = 0; px_x = 0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_map_en", map_en, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_tile_id", tile_id, 0);
        check("rst_map_addr", map_addr, 0);
        rst_n = 1'b1;
        tick();

        // scroll 0, row 0
        addr_log.delete();
        pulse_frame(0);
        wait_idle();
        check("t1_count", addr_log.size(), 21);
        check("t1_addr0", log_at(0), 0);
        check("t1_addr20", log_at(20), 20);
        pulse_line(0);
        read_px(0, 0, 0, "t1_px0");
        read_px(45, 1, 13, "t1_px45");
        read_px(700, 0, 0, "t1_px700");

        // scroll with column wrap
        addr_log.delete();
        pulse_frame(3079);
        wait_idle();
        check("t2_addr0", log_at(0), 96);
        check("t2_addr3", log_at(3), 99);
        check("t2_addr4", log_at(4), 0);
        check("t2_addr20", log_at(20), 16);
        pulse_line(0);
        read_px(0, 0, 7, "t2_px0");
        read_px(32, 1, 7, "t2_px32");
        read_px(130, 0, 9, "t2_px130");

        // next-row prefetch, front unchanged until swap
        pulse_frame(0);
        wait_idle();
        pulse_line(0);
        addr_log.delete();
        pulse_line(31);
        read_px(32, 1, 0, "t3_during");
        wait_idle();
        check("t3_count", addr_log.size(), 21);
        check("t3_addr0", log_at(0), 100);
        check("t3_addr20", log_at(20), 120);
        read_px(32, 1, 0, "t3_preswap");
        pulse_line(32);
        read_px(0, 4, 0, "t3_px0");
        read_px(32, 5, 0, "t3_px32");

        // last line of last row: no fetch
        addr_log.delete();
        pulse_line(479);
        repeat (25) tick();
        check("t4_count", addr_log.size(), 0);
        check("t4_busy", busy, 0);

        // trigger while busy
        addr_log.delete();
        pulse_line(63);
        repeat (4) tick();
        pulse_line(63);
        wait_idle();
        check("t5_count", addr_log.size(), 21);
        check("t5_addr0", log_at(0), 200);
        check("t5_addr20", log_at(20), 220);
        check("t5_overrun", overrun, 1);
        pulse_frame(0);
        check("t5_overrun_clr", overrun, 0);
        wait_idle();

        // reset mid-fetch
        pulse_line(0);
        read_px(45, 1, 13, "t6_pre");
        pulse_line(31);
        pulse_line(31);
        repeat (9) tick();
        check("t6_pre_en", map_en, 1);
        check("t6_pre_ovr", overrun, 1);
        rst_n = 1'b0;
        #1;
        check("t6_map_en", map_en, 0);
        check("t6_busy", busy, 0);
        check("t6_tile_id", tile_id, 0);
        check("t6_overrun", overrun, 0);
        tick();
        tick();
        rst_n = 1'b1;
        addr_log.delete();
        repeat (30) tick();
        check("t6_no_en", addr_log.size(), 0);
        check("t6_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

`default_nettype wire
